ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single-port data/instruction RAM between the instruction-fetch requester and the load/store requester. It sits between the pipeline's IF and MEM stages and the RAM, which has a synchronous write and a synchronous one-cycle read. The arbiter grants the RAM to one requester per cycle and forwards that requester's command. It tracks the outstanding read, returns the response to the owning requester one cycle later, and flags out-of-range or misaligned accesses without touching memory.

## Interface
- `RAM_DEPTH_WORDS`, default 4096: RAM size in 32-bit words; word addresses at or above this value are out of range.
- `MAX_DATA_BURST`, default 4: maximum consecutive data grants while fetch is waiting.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `if_req_i` in 1: fetch request; held with `if_addr_i` stable until `if_gnt_o`.
- `if_addr_i` in 32: fetch byte address; always a word read.
- `if_gnt_o` out 1: fetch granted this cycle (combinational).
- `if_rvalid_o` out 1: fetch response valid.
- `if_rdata_o` out 32: fetch data; 0 when `if_rvalid_o`=0.
- `if_err_o` out 1: fetch response carries an error; qualified by `if_rvalid_o`.
- `d_req_i` in 1: data request; held stable until `d_gnt_o`.
- `d_we_i` in 1: 1 = store, 0 = load.
- `d_addr_i` in 32: data byte address.
- `d_wdata_i` in 32: store data.
- `d_size_i` in 3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `d_gnt_o` out 1: data granted this cycle (combinational).
- `d_rvalid_o` out 1: data response valid; pulses for both loads and stores.
- `d_rdata_o` out 32: load data; 0 for stores, errors, and when not valid.
- `d_err_o` out 1: data response carries an error.
- `ram_addr_o` out 32, `ram_data_o` out 32, `ram_we_o` out 1, `ram_re_o` out 1, `ram_size_o` out 3: RAM command.
- `ram_data_i` in 32: RAM read data, valid the cycle after `ram_re_o`.

## Operation
- Arbitration is combinational each cycle. At most one grant is asserted; `gnt` requires the matching `req`.
- Default policy is data-first. Data wins whenever `d_req_i`=1, unless `burst_cnt` = `MAX_DATA_BURST` and `if_req_i`=1; in that case fetch wins.
- `burst_cnt` (width $clog2(MAX_DATA_BURST+1)):
  - increments on a data grant while `if_req_i`=1;
  - clears on any fetch grant or whenever `if_req_i`=0;
  - saturates at `MAX_DATA_BURST`.
- Error check on the granted request:
  - Out of range: `addr[31:2] >= RAM_DEPTH_WORDS`.
  - Misaligned: word with `addr[1:0]`≠0; half/halfu with `addr[0]`≠0; fetch with `addr[1:0]`≠0.
  - Invalid size: `d_size_i` ∉ {000,001,010,100,101}, or a store with size 100/101.
- A granted request with an error is still granted and still gets a response. `ram_we_o` and `ram_re_o` stay 0 for it, so memory is untouched.
- RAM command for a valid grant:
  - Fetch: addr = `if_addr_i`, re=1, we=0, size=010, data=0.
  - Data load: addr = `d_addr_i`, re=1, we=0, size = `d_size_i`.
  - Data store: addr = `d_addr_i`, re=0, we=1, size = `d_size_i`, data = `d_wdata_i`.
  - No grant: all RAM outputs 0.
- Response register (`resp_vld`, `resp_own`, `resp_err`, `resp_rd`) is loaded on every grant and cleared when there is no grant.
- Responses:
  - `if_rvalid_o` = `resp_vld` & (owner=fetch).
  - `d_rvalid_o` = `resp_vld` & (owner=data).
  - rdata = `ram_data_i` when valid & `resp_rd` & !`resp_err`, else 0.

## Timing
- Grant latency is 0 cycles: `gnt` is asserted in the same cycle as `req`, given no conflict.
- Response latency is exactly 1 cycle after the grant, for loads, stores, fetches and errors alike.
- Fully pipelined: a new grant may be issued in the same cycle a response is returned, so throughput is 1 access per cycle.
- Simultaneous requests: data is granted and fetch waits. Fetch is granted no later than the (`MAX_DATA_BURST`+1)-th cycle of contention.
- Reset:
  - All outputs are 0 the cycle after `rst` is sampled; `burst_cnt`=0.
  - While `rst`=1, grants are forced to 0.
  - A response pending at reset is dropped: no rvalid.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin. A 1-bit `last_owner` register (reset = fetch) is used; on contention, the requester that was not granted last wins. `burst_cnt` is not built, and `MAX_DATA_BURST` is ignored.
- `RAM_ARB_RR_EN` undefined: data-first with the `burst_cnt` starvation limit, as described above.

## Test plan
- Fetch only, addr 0x10 (RAM word 4 = 0xDEADBEEF): `if_gnt_o`=1 in cycle 0; cycle 1 shows `if_rvalid_o`=1 and `if_rdata_o`=0xDEADBEEF.
- Store then load:
  - Store word 0xA5A5A5A5 at 0x20: `d_rvalid_o`=1 next cycle, `d_rdata_o`=0.
  - Following lbu at 0x21: `d_rdata_o`=0x000000A5.
- Both requesting continuously, default build: grant pattern is D,D,D,D,F repeating (`MAX_DATA_BURST`=4). With `RAM_ARB_RR_EN`, the pattern is strictly alternating.
- lw at 0x22 and fetch at 0x4000: each gets rvalid=1 and err=1 with rdata=0. `ram_re_o`=0 and `ram_we_o`=0 on both grant cycles.
- Store with `d_size_i`=100: `d_err_o`=1 and memory is unchanged. A load of that word returns its old value.
- Assert `rst` in the cycle after a fetch grant: no `if_rvalid_o`; all outputs are 0 the next cycle.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between fetch and load/store; define RAM_ARB_RR_EN for round-robin arbitration
module ram_arbiter #(
  parameter int RAM_DEPTH_WORDS = 4096,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [2:0]  d_size_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic        ram_we_o,
  output logic        ram_re_o,
  output logic [2:0]  ram_size_o,
  input  logic [31:0] ram_data_i
);
  logic d_win, if_err, d_err, size_ok, d_mis, sel_err, ok, vld, rdata_ok;
  logic resp_vld, resp_own, resp_err, resp_rd;
  assign if_err = ({2'b0, if_addr_i[31:2]} >= 32'(RAM_DEPTH_WORDS)) || (if_addr_i[1:0] != 2'b00);
  assign size_ok = (d_size_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && !(d_we_i && d_size_i[2]);
  assign d_mis = (d_size_i[1:0] == 2'b10 && d_addr_i[1:0] != 2'b00) || (d_size_i[1:0] == 2'b01 && d_addr_i[0]);
  assign d_err = ({2'b0, d_addr_i[31:2]} >= 32'(RAM_DEPTH_WORDS)) || !size_ok || d_mis;
`ifdef RAM_ARB_RR_EN
  logic last_owner;
  assign d_win = d_req_i & (!if_req_i | !last_owner);
  // remember who was granted last (1 = data) so contention alternates
  always_ff @(posedge clk)
    if (rst) last_owner <= 1'b0;
    else if (if_gnt_o | d_gnt_o) last_owner <= d_gnt_o;
`else
  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_DATA_BURST);
  logic [BW-1:0] burst_cnt;
  assign d_win = d_req_i & !(burst_cnt == BMAX & if_req_i);
  // count data grants that keep fetch waiting; saturating starvation limit
  always_ff @(posedge clk)
    if (rst || !if_req_i || if_gnt_o) burst_cnt <= '0;
    else if (d_gnt_o && burst_cnt != BMAX) burst_cnt <= burst_cnt + 1'b1;
`endif
  assign d_gnt_o = !rst & d_win;
  assign if_gnt_o = !rst & if_req_i & !d_win;
  assign sel_err = d_gnt_o ? d_err : if_err;
  assign ok = (if_gnt_o | d_gnt_o) & !sel_err;
  // forward the winner's command; erroneous or absent grants leave the RAM idle
  always_comb begin
    ram_re_o = ok & (if_gnt_o | !d_we_i);
    ram_we_o = ok & d_gnt_o & d_we_i;
    ram_addr_o = !ok ? 32'h0 : d_gnt_o ? d_addr_i : if_addr_i;
    ram_size_o = !ok ? 3'b000 : d_gnt_o ? d_size_i : 3'b010;
    ram_data_o = (ok & d_gnt_o & d_we_i) ? d_wdata_i : 32'h0;
  end
  // track the single outstanding access so its response returns next cycle
  always_ff @(posedge clk)
    if (rst) begin
      resp_vld <= 1'b0;
      resp_own <= 1'b0;
      resp_err <= 1'b0;
      resp_rd <= 1'b0;
    end else begin
      resp_vld <= if_gnt_o | d_gnt_o;
      resp_own <= d_gnt_o;
      resp_err <= (if_gnt_o | d_gnt_o) & sel_err;
      resp_rd <= if_gnt_o | (d_gnt_o & !d_we_i);
    end
  assign vld = resp_vld & !rst;
  assign rdata_ok = vld & resp_rd & !resp_err;
  // route the response to its owner; reset drops anything in flight
  always_comb begin
    if_rvalid_o = vld & !resp_own;
    d_rvalid_o = vld & resp_own;
    if_err_o = vld & !resp_own & resp_err;
    d_err_o = vld & resp_own & resp_err;
    if_rdata_o = (rdata_ok & !resp_own) ? ram_data_i : 32'h0;
    d_rdata_o = (rdata_ok & resp_own) ? ram_data_i : 32'h0;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of arbitration, responses, errors and reset for ram_arbiter
module tb_ram_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [2:0] d_size = 0;
  logic if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, ram_we, ram_re;
  logic [31:0] if_rdata, d_rdata, ram_addr, ram_data, ram_rd;
  logic [2:0] ram_size;
  logic [31:0] mem [0:4095];
  int checks = 0, errors = 0;
  bit exp_d;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_size_i(d_size), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
    .d_rdata_o(d_rdata), .d_err_o(d_err),
    .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_we_o(ram_we),
    .ram_re_o(ram_re), .ram_size_o(ram_size), .ram_data_i(ram_rd)
  );

  function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [1:0] b, input logic [2:0] s);
    logic [31:0] sh;
    sh = w >> (8 * b);
    case (s)
      3'b000: return {{24{sh[7]}}, sh[7:0]};
      3'b001: return {{16{sh[15]}}, sh[15:0]};
      3'b100: return {24'h0, sh[7:0]};
      3'b101: return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (ram_we)
      case (ram_size[1:0])
        2'b00: mem[ram_addr[13:2]][8*ram_addr[1:0] +: 8] <= ram_data[7:0];
        2'b01: mem[ram_addr[13:2]][16*ram_addr[1] +: 16] <= ram_data[15:0];
        default: mem[ram_addr[13:2]] <= ram_data;
      endcase
    if (ram_re) ram_rd <= rd_ext(mem[ram_addr[13:2]], ram_addr[1:0], ram_size);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; d_size = 0;
  endtask

  task automatic dload(input logic [31:0] a, input logic [2:0] s);
    d_req = 1; d_we = 0; d_addr = a; d_size = s; d_wdata = 0;
  endtask

  task automatic dstore(input logic [31:0] a, input logic [2:0] s, input logic [31:0] w);
    d_req = 1; d_we = 1; d_addr = a; d_size = s; d_wdata = w;
  endtask

  initial begin
    if_req = 1; d_req = 1;
    @(negedge clk);
    chk("rst_if_gnt", {31'b0, if_gnt}, 0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 0);
    next_cycle();
    next_cycle();
    rst = 0; idle();
    @(negedge clk);
    chk("reset_if_rvalid", {31'b0, if_rvalid}, 0);
    chk("reset_d_rvalid", {31'b0, d_rvalid}, 0);
    chk("reset_ram_cmd", {ram_re, ram_we, ram_size, ram_addr[26:0]}, 0);

    next_cycle();
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk("fetch_gnt", {30'b0, if_gnt, d_gnt}, 2'b10);
    chk("fetch_ram_re", {31'b0, ram_re}, 1);
    chk("fetch_ram_addr", ram_addr, 32'h10);
    chk("fetch_ram_size", {29'b0, ram_size}, 3'b010);
    next_cycle();
    idle();
    @(negedge clk);
    chk("fetch_rvalid", {29'b0, if_rvalid, if_err, d_rvalid}, 3'b100);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);

    next_cycle();
    dstore(32'h20, 3'b010, 32'hA5A5A5A5);
    @(negedge clk);
    chk("sw_gnt", {30'b0, if_gnt, d_gnt}, 2'b01);
    chk("sw_ram_we", {30'b0, ram_we, ram_re}, 2'b10);
    chk("sw_ram_data", ram_data, 32'hA5A5A5A5);
    next_cycle();
    dload(32'h21, 3'b100);
    @(negedge clk);
    chk("sw_rvalid", {30'b0, d_rvalid, d_err}, 2'b10);
    chk("sw_rdata", d_rdata, 0);
    chk("lbu_ram_re", {30'b0, ram_we, ram_re}, 2'b01);
    next_cycle();
    idle();
    @(negedge clk);
    chk("lbu_rvalid", {31'b0, d_rvalid}, 1);
    chk("lbu_rdata", d_rdata, 32'h000000A5);

    next_cycle();
    if_req = 1; if_addr = 32'h10; dload(32'h10, 3'b010);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
`ifdef RAM_ARB_RR_EN
      exp_d = (i % 2) == 1;
`else
      exp_d = (i % 5) != 4;
`endif
      chk($sformatf("contend_%0d", i), {30'b0, if_gnt, d_gnt}, {30'b0, !exp_d, exp_d});
      next_cycle();
    end
    idle();
    next_cycle();

    dload(32'h22, 3'b010);
    @(negedge clk);
    chk("lw_mis_gnt", {31'b0, d_gnt}, 1);
    chk("lw_mis_ram", {30'b0, ram_we, ram_re}, 0);
    next_cycle();
    idle(); if_req = 1; if_addr = 32'h4000;
    @(negedge clk);
    chk("lw_mis_resp", {29'b0, d_rvalid, d_err, if_rvalid}, 3'b110);
    chk("lw_mis_rdata", d_rdata, 0);
    chk("f_oor_gnt", {31'b0, if_gnt}, 1);
    chk("f_oor_ram", {30'b0, ram_we, ram_re}, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("f_oor_resp", {29'b0, if_rvalid, if_err, d_rvalid}, 3'b110);
    chk("f_oor_rdata", if_rdata, 0);

    next_cycle();
    dstore(32'h10, 3'b100, 32'h12345678);
    @(negedge clk);
    chk("sbu_gnt", {31'b0, d_gnt}, 1);
    chk("sbu_ram", {30'b0, ram_we, ram_re}, 0);
    next_cycle();
    dload(32'h10, 3'b010);
    @(negedge clk);
    chk("sbu_resp", {30'b0, d_rvalid, d_err}, 2'b11);
    chk("sbu_rdata", d_rdata, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("lw_old_resp", {30'b0, d_rvalid, d_err}, 2'b10);
    chk("lw_old_rdata", d_rdata, 32'hDEADBEEF);

    next_cycle();
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk("rf_gnt", {31'b0, if_gnt}, 1);
    next_cycle();
    rst = 1;
    @(negedge clk);
    chk("rf_rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 0);
    chk("rf_rst_gnt", {30'b0, if_gnt, d_gnt}, 0);
    next_cycle();
    rst = 0; idle();
    @(negedge clk);
    chk("rf_post_resp", {27'b0, if_rvalid, if_err, d_rvalid, d_err, if_gnt}, 0);
    chk("rf_post_rdata", if_rdata | d_rdata, 0);
    chk("rf_post_ram", {ram_re, ram_we, ram_size, ram_addr[26:0]} | ram_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
